// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage core: load-use, taken branch, multi-cycle EX and data-memory wait.
// Define HAZARD_PERF_CNT_EN to add the saturating Stall_Cnt_o / Flush_Cnt_o counters.
module hazard_stall_ctrl #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ID_EX_MemRead_i,
    input  logic [4:0] ID_EX_RD_i,
    input  logic [4:0] IF_ID_RS_i,
    input  logic [4:0] IF_ID_RT_i,
    input  logic       IF_ID_UsesRT_i,
    input  logic       Branch_Taken_i,
    input  logic       MC_Start_i,
    input  logic       DMem_Ready_i,
    output logic       PCWrite_o,
    output logic       IF_ID_Write_o,
    output logic       IF_ID_Flush_o,
    output logic       ID_EX_Write_o,
    output logic       ID_EX_Flush_o,
    output logic       EX_MEM_Write_o,
    output logic       EX_MEM_Flush_o,
    output logic       MEM_WB_Flush_o,
    output logic       Stall_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] Stall_Cnt_o,
    output logic [CNT_W-1:0] Flush_Cnt_o
`endif
);

    localparam int unsigned     MC_W    = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam bit              MC_EN   = (MC_LAT >= 2);
    localparam logic [MC_W-1:0] MC_LOAD = MC_EN ? MC_W'(MC_LAT - 2) : '0;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [MC_W-1:0] r_mc_cnt;
    logic [MC_W-1:0] w_mc_cnt_nxt;
    logic            w_load_use;
    logic            w_pc_we;
    logic            w_ifid_we;
    logic            w_ifid_fl;
    logic            w_idex_we;
    logic            w_idex_fl;
    logic            w_exmem_we;
    logic            w_exmem_fl;
    logic            w_memwb_fl;

    assign w_load_use = ID_EX_MemRead_i && (ID_EX_RD_i != 5'd0) &&
                        ((ID_EX_RD_i == IF_ID_RS_i) ||
                         (IF_ID_UsesRT_i && (ID_EX_RD_i == IF_ID_RT_i)));

    // State register and multi-cycle countdown
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_RUN;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

    // Next state; the countdown keeps running through a memory freeze so release lands on the first ready cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_mc_cnt_nxt = r_mc_cnt;
        if (!DMem_Ready_i) begin
            if (r_mc_cnt != '0) begin
                w_mc_cnt_nxt = r_mc_cnt - MC_W'(1);
            end else begin
                w_mc_cnt_nxt = '0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (MC_EN && MC_Start_i) begin
                        w_state_nxt  = ST_MC_BUSY;
                        w_mc_cnt_nxt = MC_LOAD;
                    end else begin
                        w_state_nxt  = ST_RUN;
                    end
                end
                ST_MC_BUSY: begin
                    if (r_mc_cnt != '0) begin
                        w_mc_cnt_nxt = r_mc_cnt - MC_W'(1);
                    end else begin
                        w_state_nxt  = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt  = ST_RUN;
                    w_mc_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output decode: reset, then freeze > multi-cycle > branch > load-use
    always_comb begin
        w_pc_we    = 1'b1;
        w_ifid_we  = 1'b1;
        w_ifid_fl  = 1'b0;
        w_idex_we  = 1'b1;
        w_idex_fl  = 1'b0;
        w_exmem_we = 1'b1;
        w_exmem_fl = 1'b0;
        w_memwb_fl = 1'b0;
        if (!rst_n_i) begin
            w_pc_we    = 1'b0;
            w_ifid_we  = 1'b0;
            w_ifid_fl  = 1'b1;
            w_idex_we  = 1'b0;
            w_idex_fl  = 1'b1;
            w_exmem_we = 1'b0;
            w_exmem_fl = 1'b1;
            w_memwb_fl = 1'b1;
        end else if (!DMem_Ready_i) begin
            w_pc_we    = 1'b0;
            w_ifid_we  = 1'b0;
            w_idex_we  = 1'b0;
            w_exmem_we = 1'b0;
            w_memwb_fl = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (MC_EN && MC_Start_i) begin
                        w_pc_we    = 1'b0;
                        w_ifid_we  = 1'b0;
                        w_idex_we  = 1'b0;
                        w_exmem_fl = 1'b1;
                    end else if (Branch_Taken_i) begin
                        w_ifid_fl  = 1'b1;
                        w_idex_fl  = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_we    = 1'b0;
                        w_ifid_we  = 1'b0;
                        w_idex_fl  = 1'b1;
                    end else begin
                        w_pc_we    = 1'b1;
                    end
                end
                ST_MC_BUSY: begin
                    if (r_mc_cnt != '0) begin
                        w_pc_we    = 1'b0;
                        w_ifid_we  = 1'b0;
                        w_idex_we  = 1'b0;
                        w_exmem_fl = 1'b1;
                    end else begin
                        w_pc_we    = 1'b1;
                    end
                end
                default: begin
                    w_pc_we    = 1'b1;
                end
            endcase
        end
    end

    assign PCWrite_o      = w_pc_we;
    assign IF_ID_Write_o  = w_ifid_we;
    assign IF_ID_Flush_o  = w_ifid_fl;
    assign ID_EX_Write_o  = w_idex_we;
    assign ID_EX_Flush_o  = w_idex_fl;
    assign EX_MEM_Write_o = w_exmem_we;
    assign EX_MEM_Flush_o = w_exmem_fl;
    assign MEM_WB_Flush_o = w_memwb_fl;
    assign Stall_o        = rst_n_i & ~w_pc_we;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Saturating stall / front-end flush event counters
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_stall_cnt <= w_pc_we   ? r_stall_cnt : sat_inc(r_stall_cnt);
            r_flush_cnt <= w_ifid_fl ? sat_inc(r_flush_cnt) : r_flush_cnt;
        end
    end

    assign Stall_Cnt_o = r_stall_cnt;
    assign Flush_Cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, directed multi-cycle sequences, random vs. model.
module tb_hazard_stall_ctrl;

    localparam int unsigned TB_MC_LAT = 4;
    localparam int unsigned TB_CNT_W  = 4;
    localparam int          CMAX      = (1 << TB_CNT_W) - 1;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, Stall}
    localparam logic [8:0] DEF_V = 9'b110101000;
    localparam logic [8:0] RST_V = 9'b001010110;
    localparam logic [8:0] FRZ_V = 9'b000000011;
    localparam logic [8:0] MC_V  = 9'b000001101;
    localparam logic [8:0] BR_V  = 9'b111111000;
    localparam logic [8:0] LU_V  = 9'b000111001;

    typedef struct {
        logic       rst_n;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic       br;
        logic       mc;
        logic       rdy;
        logic [8:0] exp;
        string      nm;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_n_i, ID_EX_MemRead_i, IF_ID_UsesRT_i, Branch_Taken_i, MC_Start_i, DMem_Ready_i;
    logic [4:0] ID_EX_RD_i, IF_ID_RS_i, IF_ID_RT_i;
    logic       PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Write_o, ID_EX_Flush_o;
    logic       EX_MEM_Write_o, EX_MEM_Flush_o, MEM_WB_Flush_o, Stall_o;
    logic [TB_CNT_W-1:0] Stall_Cnt_o, Flush_Cnt_o;
    logic [8:0] w_out;

    int n_checks = 0;
    int n_errors = 0;
    int m_age    = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    always #5 clk_i = ~clk_i;

    hazard_stall_ctrl #(.MC_LAT(TB_MC_LAT), .CNT_W(TB_CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_RD_i(ID_EX_RD_i),
        .IF_ID_RS_i(IF_ID_RS_i), .IF_ID_RT_i(IF_ID_RT_i), .IF_ID_UsesRT_i(IF_ID_UsesRT_i),
        .Branch_Taken_i(Branch_Taken_i), .MC_Start_i(MC_Start_i), .DMem_Ready_i(DMem_Ready_i),
        .PCWrite_o(PCWrite_o), .IF_ID_Write_o(IF_ID_Write_o), .IF_ID_Flush_o(IF_ID_Flush_o),
        .ID_EX_Write_o(ID_EX_Write_o), .ID_EX_Flush_o(ID_EX_Flush_o),
        .EX_MEM_Write_o(EX_MEM_Write_o), .EX_MEM_Flush_o(EX_MEM_Flush_o),
        .MEM_WB_Flush_o(MEM_WB_Flush_o), .Stall_o(Stall_o)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Cnt_o(Stall_Cnt_o), .Flush_Cnt_o(Flush_Cnt_o)
`endif
    );

`ifndef HAZARD_PERF_CNT_EN
    assign Stall_Cnt_o = '0;
    assign Flush_Cnt_o = '0;
`endif

    assign w_out = {PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Write_o, ID_EX_Flush_o,
                    EX_MEM_Write_o, EX_MEM_Flush_o, MEM_WB_Flush_o, Stall_o};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst_n, input logic mr, input logic [4:0] rd,
                                input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                                input logic br, input logic mc, input logic rdy,
                                input logic [8:0] exp, input string nm);
        vec_t v;
        v.rst_n = rst_n; v.mr = mr; v.rd = rd; v.rs = rs; v.rt = rt; v.ut = ut;
        v.br = br; v.mc = mc; v.rdy = rdy; v.exp = exp; v.nm = nm;
        return v;
    endfunction

    // Reference: m_age is the index of the current EX cycle of a multi-cycle op (0 = none in flight)
    function automatic logic [8:0] model_out();
        logic lu;
        lu = ID_EX_MemRead_i && (ID_EX_RD_i != 5'd0) &&
             (ID_EX_RD_i == IF_ID_RS_i || (IF_ID_UsesRT_i && ID_EX_RD_i == IF_ID_RT_i));
        if (!rst_n_i)                           return RST_V;
        if (!DMem_Ready_i)                      return FRZ_V;
        if (m_age > 0)                          return (m_age < TB_MC_LAT) ? MC_V : DEF_V;
        if (MC_Start_i && TB_MC_LAT >= 2)       return MC_V;
        if (Branch_Taken_i)                     return BR_V;
        if (lu)                                 return LU_V;
        return DEF_V;
    endfunction

    task automatic model_update();
        logic [8:0] o;
        o = model_out();
        if (!rst_n_i) begin
            m_age = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!o[8] && m_stall < CMAX) m_stall++;
            if (o[6] && m_flush < CMAX) m_flush++;
            if (m_age > 0) m_age = (DMem_Ready_i && m_age >= TB_MC_LAT) ? 0 : m_age + 1;
            else if (DMem_Ready_i && MC_Start_i && TB_MC_LAT >= 2) m_age = 2;
        end
    endtask

    task automatic step(input vec_t v, input bit use_tbl);
        logic [8:0] e;
        @(negedge clk_i);
        rst_n_i = v.rst_n; ID_EX_MemRead_i = v.mr; ID_EX_RD_i = v.rd; IF_ID_RS_i = v.rs;
        IF_ID_RT_i = v.rt; IF_ID_UsesRT_i = v.ut; Branch_Taken_i = v.br; MC_Start_i = v.mc;
        DMem_Ready_i = v.rdy;
        #1;
        e = use_tbl ? v.exp : model_out();
        check(v.nm, 32'(w_out), 32'(e));
`ifdef HAZARD_PERF_CNT_EN
        check({v.nm, "_stall_cnt"}, 32'(Stall_Cnt_o), 32'(m_stall));
        check({v.nm, "_flush_cnt"}, 32'(Flush_Cnt_o), 32'(m_flush));
`endif
        model_update();
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        rst_n_i = 1'b0; ID_EX_MemRead_i = 1'b0; ID_EX_RD_i = 5'd0; IF_ID_RS_i = 5'd0;
        IF_ID_RT_i = 5'd0; IF_ID_UsesRT_i = 1'b0; Branch_Taken_i = 1'b0; MC_Start_i = 1'b0;
        DMem_Ready_i = 1'b1;

        tbl[0]  = mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF_V, "idle");
        tbl[1]  = mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, LU_V,  "lu_rs");
        tbl[2]  = mk(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, DEF_V, "lu_rd0");
        tbl[3]  = mk(1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, LU_V,  "lu_rt");
        tbl[4]  = mk(1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, DEF_V, "lu_rt_unused");
        tbl[5]  = mk(1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, DEF_V, "no_memread");
        tbl[6]  = mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, BR_V,  "br_over_lu");
        tbl[7]  = mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, BR_V,  "br");
        tbl[8]  = mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, MC_V,  "mc_over_br");
        tbl[9]  = mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ_V, "frz_over_br");
        tbl[10] = mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ_V, "frz_over_mc");
        tbl[11] = mk(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, RST_V, "reset_in");

        step(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, RST_V, "reset"), 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(tbl[i], 1'b1);
            step(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, RST_V, "reset_between"), 1'b1);
        end

        // Multi-cycle op: EX held t..t+2, release at t+3 (LU/branch ignored), RUN again at t+4
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MC_V,  "mc_t0"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, MC_V,  "mc_t1"), 1'b1);
        step(mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, MC_V,  "mc_t2"), 1'b1);
        step(mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, DEF_V, "mc_t3_release"), 1'b1);
        step(mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, LU_V,  "mc_t4_run"), 1'b1);

        // Freeze over the last MC cycles: release only on the first ready cycle
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MC_V,  "frz_t0"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, MC_V,  "frz_t1"), 1'b1);
        for (int i = 2; i <= 5; i++)
            step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ_V, "frz_hold"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF_V, "frz_t6_release"), 1'b1);
        step(mk(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, LU_V,  "frz_t7_run"), 1'b1);

        // Reset in the middle of an MC op aborts to RUN
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MC_V,  "rmc_t0"), 1'b1);
        step(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, RST_V, "rmc_t1"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF_V, "rmc_t2"), 1'b1);
        step(mk(1'b1, 1'b1, 5'd2, 5'd9, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, LU_V,  "rmc_t3_run"), 1'b1);

`ifdef HAZARD_PERF_CNT_EN
        step(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, RST_V, "pc_reset"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MC_V,  "pc_mc0"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, MC_V,  "pc_mc1"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, MC_V,  "pc_mc2"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF_V, "pc_rel"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, BR_V,  "pc_br"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF_V, "pc_idle"), 1'b1);
        check("stall_cnt_3", 32'(Stall_Cnt_o), 32'd3);
        check("flush_cnt_1", 32'(Flush_Cnt_o), 32'd1);
        for (int i = 0; i < 20; i++)
            step(mk(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, LU_V, "sat_lu"), 1'b1);
        for (int i = 0; i < 20; i++)
            step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, BR_V, "sat_br"), 1'b1);
        step(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF_V, "sat_idle"), 1'b1);
        check("stall_cnt_sat", 32'(Stall_Cnt_o), 32'(CMAX));
        check("flush_cnt_sat", 32'(Flush_Cnt_o), 32'(CMAX));
`endif

        for (int i = 0; i < 3000; i++) begin
            rv = mk(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) != 0), DEF_V, "rand");
            step(rv, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
